mem_sched: RTL and testbench

Byte-serial memory scheduler sitting between the CPU pipeline and the 8-bit RAM/IO bus. Arbitrates between the instruction-fetch port and the load/store port, then sequences each multi-byte access into per-byte bus cycles with little-endian assembly and disassembly. Handles flush-abort of fetches, `rdy` pausing and, optionally, UART back-pressure.

---
 rtl/mem_sched_if.sv | 46 ++++
 rtl/mem_sched.sv | 232 +++++++++++++++++++++++
 tb/tb_mem_sched.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_sched_if.sv
// mem_sched_if: CPU-side request ports and 8-bit RAM/IO bus of mem_sched.
// master = pipeline + bus agent side, slave = the scheduler.
interface mem_sched_if #(
    parameter int ADDR_W = 32
);
    // instruction-fetch port
    logic              if_request;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_inst;
    logic              if_enable;
    logic              flush;

    // load/store port
    logic              ld_req;
    logic              st_req;
    logic [ADDR_W-1:0] ls_addr;
    logic [2:0]        ls_nbytes;
    logic [31:0]       ls_wdata;
    logic [31:0]       ls_rdata;
    logic              ls_done;

    // byte-serial RAM/IO bus
    logic              io_buffer_full;
    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;

    modport master (
        output if_request, if_addr, flush,
        output ld_req, st_req, ls_addr, ls_nbytes, ls_wdata,
        output io_buffer_full, ram_din,
        input  if_inst, if_enable,
        input  ls_rdata, ls_done,
        input  ram_dout, ram_a, ram_wr
    );

    modport slave (
        input  if_request, if_addr, flush,
        input  ld_req, st_req, ls_addr, ls_nbytes, ls_wdata,
        input  io_buffer_full, ram_din,
        output if_inst, if_enable,
        output ls_rdata, ls_done,
        output ram_dout, ram_a, ram_wr
    );
endinterface

// File: rtl/mem_sched.sv
// mem_sched: arbitrates fetch vs load/store and serialises each access
// into little-endian byte cycles. Optional UART wait: MEM_SCHED_IO_WAIT_EN.
module mem_sched #(
    parameter int ADDR_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    mem_sched_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_IO_WAIT,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        k_q, k_d;
    logic [2:0]        n_q, n_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       data_q, data_d;
    logic              fetch_q, fetch_d;

`ifdef MEM_SCHED_IO_WAIT_EN
    logic              io_q, io_d;
    logic              gap_q, gap_d;
    logic              io_hit;
`else
    logic              unused_io;
`endif

    logic [ADDR_W-1:0] byte_addr;
    logic [7:0]        wbyte;
    logic [3:0]        k_inc;
    logic              wr_last;
    logic              rd_last;

    assign byte_addr = addr_q + ADDR_W'(k_q);
    assign k_inc     = {1'b0, k_q} + 4'd1;
    assign wr_last   = (k_inc >= {1'b0, n_q});
    assign rd_last   = (k_q >= n_q);

`ifdef MEM_SCHED_IO_WAIT_EN
    assign io_hit = (bus.ls_addr[17:16] == 2'b11);
`else
    assign unused_io = bus.io_buffer_full;
`endif

    // Select the store byte for the current lane.
    always_comb begin
        wbyte = wdata_q[7:0];
        case (k_q[1:0])
            2'd1:    wbyte = wdata_q[15:8];
            2'd2:    wbyte = wdata_q[23:16];
            2'd3:    wbyte = wdata_q[31:24];
            default: wbyte = wdata_q[7:0];
        endcase
    end

    // Next-state logic; rdy low leaves every register at its value.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        fetch_d = fetch_q;
`ifdef MEM_SCHED_IO_WAIT_EN
        io_d    = io_q;
        gap_d   = gap_q;
`endif
        if (rdy) begin
            unique case (state_q)
                S_IDLE: begin
                    k_d    = '0;
                    data_d = '0;
                    if (bus.st_req) begin
                        addr_d  = bus.ls_addr;
                        n_d     = bus.ls_nbytes;
                        wdata_d = bus.ls_wdata;
                        fetch_d = 1'b0;
                        state_d = S_WRITE;
`ifdef MEM_SCHED_IO_WAIT_EN
                        io_d  = io_hit;
                        gap_d = 1'b0;
                        if (io_hit && bus.io_buffer_full)
                            state_d = S_IO_WAIT;
`endif
                    end else if (bus.ld_req) begin
                        addr_d  = bus.ls_addr;
                        n_d     = bus.ls_nbytes;
                        fetch_d = 1'b0;
                        state_d = S_READ;
`ifdef MEM_SCHED_IO_WAIT_EN
                        io_d  = 1'b0;
                        gap_d = 1'b0;
`endif
                    end else if (bus.if_request && !bus.flush) begin
                        addr_d  = bus.if_addr;
                        n_d     = 3'd4;
                        fetch_d = 1'b1;
                        state_d = S_READ;
`ifdef MEM_SCHED_IO_WAIT_EN
                        io_d  = 1'b0;
                        gap_d = 1'b0;
`endif
                    end
                end
                S_READ: begin
                    if (fetch_q && bus.flush) begin
                        state_d = S_IDLE;
                    end else begin
                        // ram_din answers the address issued last cycle
                        case (k_q)
                            3'd1:    data_d[7:0]   = bus.ram_din;
                            3'd2:    data_d[15:8]  = bus.ram_din;
                            3'd3:    data_d[23:16] = bus.ram_din;
                            3'd4:    data_d[31:24] = bus.ram_din;
                            default: data_d = data_q;
                        endcase
                        if (rd_last)
                            state_d = S_DONE;
                        else
                            k_d = k_inc[2:0];
                    end
                end
                S_WRITE: begin
                    if (wr_last) begin
                        state_d = S_DONE;
                    end else begin
                        k_d     = k_inc[2:0];
                        state_d = S_WRITE;
`ifdef MEM_SCHED_IO_WAIT_EN
                        // idle bus cycle after each IO byte
                        if (io_q) begin
                            state_d = S_IO_WAIT;
                            gap_d   = 1'b1;
                        end
`endif
                    end
                end
`ifdef MEM_SCHED_IO_WAIT_EN
                S_IO_WAIT: begin
                    if (gap_q)
                        gap_d = 1'b0;
                    else if (!bus.io_buffer_full)
                        state_d = S_WRITE;
                end
`endif
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            n_q     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            fetch_q <= 1'b0;
`ifdef MEM_SCHED_IO_WAIT_EN
            io_q    <= 1'b0;
            gap_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            fetch_q <= fetch_d;
`ifdef MEM_SCHED_IO_WAIT_EN
            io_q    <= io_d;
            gap_q   <= gap_d;
`endif
        end
    end

    // Bus drive and completion pulses decoded from the current state.
    always_comb begin
        bus.ram_a     = '0;
        bus.ram_dout  = '0;
        bus.ram_wr    = 1'b0;
        bus.if_enable = 1'b0;
        bus.if_inst   = '0;
        bus.ls_done   = 1'b0;
        bus.ls_rdata  = '0;
        unique case (state_q)
            S_READ: begin
                if (!rd_last)
                    bus.ram_a = byte_addr;
            end
            S_WRITE: begin
                bus.ram_a    = byte_addr;
                bus.ram_dout = wbyte;
                bus.ram_wr   = rdy && !rst;
            end
            S_DONE: begin
                if (rdy && !rst) begin
                    if (fetch_q) begin
                        if (!bus.flush) begin
                            bus.if_enable = 1'b1;
                            bus.if_inst   = data_q;
                        end
                    end else begin
                        bus.ls_done  = 1'b1;
                        bus.ls_rdata = data_q;
                    end
                end
            end
            default: begin
                bus.ram_a = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_sched.sv
// tb_mem_sched: directed and random transactions checked against a
// cycle-count/byte-list reference model and a rdy-gated RAM model.
module tb_mem_sched;

    localparam int AW      = 32;
    localparam int K_FETCH = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    int   n_chk  = 0;
    int   n_fail = 0;

    mem_sched_if #(.ADDR_W(AW)) bus ();

    mem_sched #(.ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    logic [7:0] ram_mem [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];
    logic [7:0] ram_q = 8'h00;

    assign bus.ram_din = ram_q;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        case (a)
            32'h100: return 8'h13;
            32'h101: return 8'h05;
            32'h102: return 8'h10;
            32'h103: return 8'h00;
            32'h200: return 8'hAA;
            32'h201: return 8'hBB;
            default: return a[7:0] ^ {a[11:8], a[15:12]} ^ a[23:16] ^ a[31:24] ^ 8'h5C;
        endcase
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    // Synchronous RAM: one-cycle read latency, frozen together with rdy.
    always @(posedge clk) begin
        if (rdy) begin
            if (bus.ram_wr)
                ram_mem[bus.ram_a] = bus.ram_dout;
            ram_q <= ram_rd(bus.ram_a);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic quiet();
        bus.if_request     = 1'b0;
        bus.if_addr        = '0;
        bus.flush          = 1'b0;
        bus.ld_req         = 1'b0;
        bus.st_req         = 1'b0;
        bus.ls_addr        = '0;
        bus.ls_nbytes      = 3'd0;
        bus.ls_wdata       = '0;
        bus.io_buffer_full = 1'b0;
    endtask

    // One transaction from an idle DUT; rmask bit c low pauses cycle c.
    task automatic do_txn(input int kind, input logic [31:0] a, input int n,
                          input logic [31:0] wd, input logic [31:0] rmask,
                          output int done_c, output logic [31:0] got);
        int          nb;
        int          lat;
        int          act;
        bit          fin;
        logic [31:0] exp_w;
        nb  = (kind == K_FETCH) ? 4 : n;
        lat = (kind == K_STORE) ? nb + 1 : nb + 2;
        exp_w = '0;
        for (int i = 0; i < nb; i++)
            exp_w[8*i +: 8] = (kind == K_STORE) ? wd[8*i +: 8] : ref_rd(a + 32'(i));
        act    = 0;
        fin    = 1'b0;
        done_c = -1;
        got    = '0;
        bus.if_addr    = a;
        bus.ls_addr    = a;
        bus.ls_nbytes  = 3'(n);
        bus.ls_wdata   = wd;
        bus.if_request = (kind == K_FETCH);
        bus.ld_req     = (kind == K_LOAD);
        bus.st_req     = (kind == K_STORE);
        for (int c = 0; c < 80 && !fin; c++) begin
            rdy = (c == 0 || c > 31) ? 1'b1 : rmask[c];
            #1;
            if (rdy) begin
                if (c > 0)
                    act++;
                if (c == 0)
                    chk("txn_idle_addr", bus.ram_a, 32'h0);
                if (act >= 1 && act <= nb) begin
                    chk("txn_addr", bus.ram_a, a + 32'(act - 1));
                    chk("txn_wr", 32'(bus.ram_wr), 32'(kind == K_STORE));
                    if (kind == K_STORE)
                        chk("txn_dout", 32'(bus.ram_dout), 32'(wd[8*(act-1) +: 8]));
                end
                if (act == lat) begin
                    fin    = 1'b1;
                    done_c = c;
                    got    = (kind == K_FETCH) ? bus.if_inst : bus.ls_rdata;
                    chk("txn_done", 32'((kind == K_FETCH) ? bus.if_enable : bus.ls_done), 32'h1);
                    chk("txn_other", 32'((kind == K_FETCH) ? bus.ls_done : bus.if_enable), 32'h0);
                    if (kind != K_STORE)
                        chk("txn_data", got, exp_w);
                    chk("txn_done_addr", bus.ram_a, 32'h0);
                end else begin
                    chk("txn_nodone", 32'({bus.if_enable, bus.ls_done}), 32'h0);
                end
            end else begin
                chk("pause_wr", 32'(bus.ram_wr), 32'h0);
                chk("pause_nodone", 32'({bus.if_enable, bus.ls_done}), 32'h0);
            end
            @(posedge clk);
            #1;
        end
        quiet();
        rdy = 1'b1;
        chk("txn_finished", 32'(fin), 32'h1);
        if (kind == K_STORE)
            for (int i = 0; i < nb; i++)
                ref_mem[a + 32'(i)] = wd[8*i +: 8];
    endtask

    initial begin
        int          dc;
        logic [31:0] got;
        int          kind;
        int          nsel;
        logic [31:0] a;
        logic [31:0] m;

        rst = 1'b1;
        rdy = 1'b1;
        quiet();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_if_enable", 32'(bus.if_enable), 32'h0);
        chk("rst_if_inst", bus.if_inst, 32'h0);
        chk("rst_ls_done", 32'(bus.ls_done), 32'h0);
        chk("rst_ls_rdata", bus.ls_rdata, 32'h0);
        chk("rst_ram_a", bus.ram_a, 32'h0);
        chk("rst_ram_dout", 32'(bus.ram_dout), 32'h0);
        chk("rst_ram_wr", 32'(bus.ram_wr), 32'h0);
        @(posedge clk);
        #1;

        // fetch of 0x100
        do_txn(K_FETCH, 32'h100, 4, 32'h0, '1, dc, got);
        chk("fetch_cycle", 32'(dc), 32'd6);
        chk("fetch_inst", got, 32'h00100513);

        // store across 0x20000
        do_txn(K_STORE, 32'h1FFFE, 4, 32'hDEADBEEF, '1, dc, got);
        chk("store_cycle", 32'(dc), 32'd5);
        do_txn(K_LOAD, 32'h1FFFE, 4, 32'h0, '1, dc, got);
        chk("store_readback", got, 32'hDEADBEEF);

        // load wrapping past the top of the address space
        do_txn(K_LOAD, 32'hFFFFFFFE, 4, 32'h0, '1, dc, got);
        chk("wrap_cycle", 32'(dc), 32'd6);

        // rdy low in cycles 2..4 of a 4-byte load
        do_txn(K_LOAD, 32'h100, 4, 32'h0, ~32'h1C, dc, got);
        chk("pause_cycle", 32'(dc), 32'd9);
        chk("pause_word", got, 32'h00100513);

        // fetch and 2-byte load requested together
        bus.if_request = 1'b1;
        bus.if_addr    = 32'h100;
        bus.ld_req     = 1'b1;
        bus.ls_addr    = 32'h200;
        bus.ls_nbytes  = 3'd2;
        for (int c = 0; c <= 11; c++) begin
            if (c == 5)
                bus.ld_req = 1'b0;
            #1;
            if (c == 1)
                chk("cont_addr0", bus.ram_a, 32'h200);
            if (c == 2)
                chk("cont_addr1", bus.ram_a, 32'h201);
            if (c == 4) begin
                chk("cont_ls_done", 32'(bus.ls_done), 32'h1);
                chk("cont_rdata", bus.ls_rdata, 32'h0000BBAA);
                chk("cont_no_if", 32'(bus.if_enable), 32'h0);
            end
            if (c == 5)
                chk("cont_idle_addr", bus.ram_a, 32'h0);
            if (c == 6)
                chk("cont_fetch_addr", bus.ram_a, 32'h100);
            if (c == 11) begin
                chk("cont_if_enable", 32'(bus.if_enable), 32'h1);
                chk("cont_if_inst", bus.if_inst, 32'h00100513);
            end
            @(posedge clk);
            #1;
        end
        quiet();

        // flush in cycle 3 of a fetch with a load waiting
        bus.if_request = 1'b1;
        bus.if_addr    = 32'h100;
        for (int c = 0; c <= 8; c++) begin
            if (c == 3) begin
                bus.flush     = 1'b1;
                bus.ld_req    = 1'b1;
                bus.ls_addr   = 32'h200;
                bus.ls_nbytes = 3'd1;
            end
            if (c == 4) begin
                bus.flush      = 1'b0;
                bus.if_request = 1'b0;
            end
            if (c == 8)
                bus.ld_req = 1'b0;
            #1;
            chk("flush_no_if", 32'(bus.if_enable), 32'h0);
            if (c == 3)
                chk("flush_addr2", bus.ram_a, 32'h102);
            if (c == 4)
                chk("flush_idle", bus.ram_a, 32'h0);
            if (c == 5)
                chk("flush_ld_addr", bus.ram_a, 32'h200);
            if (c == 7) begin
                chk("flush_ld_done", 32'(bus.ls_done), 32'h1);
                chk("flush_ld_data", bus.ls_rdata, 32'h000000AA);
            end
            @(posedge clk);
            #1;
        end
        quiet();

        // flush while idle, then flush in the done cycle
        bus.if_request = 1'b1;
        bus.if_addr    = 32'h100;
        bus.flush      = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            if (c == 1)
                bus.flush = 1'b0;
            if (c == 7)
                bus.flush = 1'b1;
            if (c == 8) begin
                bus.flush      = 1'b0;
                bus.if_request = 1'b0;
            end
            #1;
            if (c == 1)
                chk("iflush_not_taken", bus.ram_a, 32'h0);
            if (c == 2)
                chk("iflush_taken", bus.ram_a, 32'h100);
            if (c == 7) begin
                chk("dflush_no_if", 32'(bus.if_enable), 32'h0);
                chk("dflush_no_inst", bus.if_inst, 32'h0);
            end
            if (c >= 8)
                chk("dflush_idle", bus.ram_a, 32'h0);
            @(posedge clk);
            #1;
        end
        quiet();

        // reset in the middle of a store
        bus.st_req    = 1'b1;
        bus.ls_addr   = 32'h500;
        bus.ls_nbytes = 3'd4;
        bus.ls_wdata  = 32'h11223344;
        for (int c = 0; c <= 6; c++) begin
            if (c == 2)
                rst = 1'b1;
            if (c == 3) begin
                rst        = 1'b0;
                bus.st_req = 1'b0;
            end
            #1;
            if (c == 1)
                chk("rst_mid_wr", 32'(bus.ram_wr), 32'h1);
            if (c >= 3) begin
                chk("rst_mid_nowr", 32'(bus.ram_wr), 32'h0);
                chk("rst_mid_nodone", 32'(bus.ls_done), 32'h0);
                chk("rst_mid_addr", bus.ram_a, 32'h0);
            end
            @(posedge clk);
            #1;
        end
        quiet();

        // random traffic with random rdy pauses
        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 2));
            nsel = int'($urandom_range(0, 2));
            if (t % 2 == 0)
                a = 32'h4000 + $urandom_range(0, 15);
            else
                a = $urandom & ~32'h0001_0000;
            m = (t % 3 == 0) ? ($urandom | 32'h1) : '1;
            do_txn(kind, a, (nsel == 0) ? 1 : (nsel == 1) ? 2 : 4, $urandom, m, dc, got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
